// File: rtl/ram_copy_engine_if.sv
// RAM-side bus of the copy engine: address, write data, write enable, read data.
// The engine drives the master side; the RAM sits on the slave side.
interface ram_copy_engine_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_in;
  logic              mem_load;
  logic [15:0]       mem_out;

  modport master (
    output mem_addr,
    output mem_in,
    output mem_load,
    input  mem_out
  );

  modport slave (
    input  mem_addr,
    input  mem_in,
    input  mem_load,
    output mem_out
  );
endinterface

// File: rtl/ram_copy_engine.sv
// Block COPY / FILL engine for a single-port 16-bit RAM.
// Moves one word per WR cycle; COPY interleaves an RD cycle before each write.
module ram_copy_engine #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
  input  logic [15:0]       fill_val,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  ram_copy_engine_if.master mem
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    FIN
  } state_t;

  state_t            state;
  logic              fill;
  logic [ADDR_W-1:0] sptr;
  logic [ADDR_W-1:0] dptr;
  logic [ADDR_W-1:0] cnt;
  logic [15:0]       wdata;

  // wdata doubles as the read-back register, so mem_in holds outside WR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fill  <= 1'b0;
      sptr  <= '0;
      dptr  <= '0;
      cnt   <= '0;
      wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            fill <= mode;
            sptr <= src;
            dptr <= dst;
            cnt  <= len;
            if (len == '0) begin
              state <= FIN;
            end else if (mode) begin
              wdata <= fill_val;
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            wdata <= mem.mem_out;
            sptr  <= sptr + 1'b1;
            state <= WR;
          end
        end
        WR: begin
          dptr <= dptr + 1'b1;
          cnt  <= cnt - 1'b1;
          if (abort) begin
            state <= IDLE;
          end else if (cnt == ADDR_W'(1)) begin
            state <= FIN;
          end else if (fill) begin
            state <= WR;
          end else begin
            state <= RD;
          end
        end
        FIN: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign done         = (state == FIN);
  assign mem.mem_load = (state == WR);
  assign mem.mem_in   = wdata;

  always_comb begin
    mem.mem_addr = '0;
    unique case (1'b1)
      (state == RD): mem.mem_addr = sptr;
      (state == WR): mem.mem_addr = dptr;
      default:       mem.mem_addr = '0;
    endcase
  end

endmodule

// File: tb/tb_ram_copy_engine.sv
// Testbench for ram_copy_engine: RAM model on the bus, word-level
// reference model of COPY/FILL, directed vectors plus random jobs.
module tb_ram_copy_engine;
  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] src = '0;
  logic [AW-1:0] dst = '0;
  logic [AW-1:0] len = '0;
  logic [15:0]   fill_val = '0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  logic [15:0]   ram   [0:DEPTH-1];
  logic [15:0]   model [0:DEPTH-1];
  int            waddr [$];

  ram_copy_engine_if #(.ADDR_W(AW)) bus ();

  ram_copy_engine #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .fill_val (fill_val),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .mem      (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.mem_out = ram[bus.mem_addr];

  always @(posedge clk)
    if (bus.mem_load) ram[bus.mem_addr] <= bus.mem_in;

  task automatic init_mem();
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]   = 16'($urandom);
      model[i] = ram[i];
    end
  endtask

  // Reference: ascending word-by-word job with modulo addressing
  task automatic model_job(input logic m, input int s, input int d,
                           input int n, input logic [15:0] fv);
    for (int i = 0; i < n; i++)
      model[(d + i) % DEPTH] = m ? fv : model[(s + i) % DEPTH];
  endtask

  task automatic check_ram(input string name);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < DEPTH; i++)
      if (ram[i] !== model[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s ram: %0d words differ, first at %h got %h want %h",
               name, bad, first, ram[first], model[first]);
    end
  endtask

  task automatic start_job(input logic m, input int s, input int d,
                           input int n, input logic [15:0] fv);
    @(negedge clk);
    mode     = m;
    src      = AW'(s);
    dst      = AW'(d);
    len      = AW'(n);
    fill_val = fv;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Steps through the busy window counting busy/done/write cycles
  task automatic run(input int budget, input int pulse_at, input int abort_at,
                     output int nb, output int nd, output int nl);
    nb = 0;
    nd = 0;
    nl = 0;
    waddr.delete();
    while (busy && nb < budget) begin
      nb++;
      if (done) nd++;
      if (bus.mem_load) begin
        nl++;
        waddr.push_back(int'(bus.mem_addr));
      end
      start = (nb == pulse_at);
      abort = (nb == abort_at);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    if (nb >= budget) begin
      tests++;
      fails++;
      $display("FAIL timeout: busy still %b after %0d cycles", busy, nb);
    end
  endtask

  task automatic check_job(input string name, input int nb, input int nd,
                           input int nl, input int eb, input int ed,
                           input int el);
    tests++;
    if (nb !== eb || nd !== ed || nl !== el) begin
      fails++;
      $display("FAIL %s counts: busy %0d done %0d load %0d, want %0d %0d %0d",
               name, nb, nd, nl, eb, ed, el);
    end
  endtask

  task automatic test_reset();
    int nb, nd, nl;
    rst_n = 1'b0;
    #3;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.mem_load !== 1'b0 ||
        bus.mem_addr !== '0 || bus.mem_in !== '0) begin
      fails++;
      $display("FAIL reset_state: busy %b done %b load %b addr %h in %h, want all 0",
               busy, done, bus.mem_load, bus.mem_addr, bus.mem_in);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_job(1'b1, 0, 'h200, 8, 16'h5A5A);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.mem_load !== 1'b0 ||
        bus.mem_in !== '0) begin
      fails++;
      $display("FAIL reset_mid_wr: busy %b done %b load %b in %h, want 0",
               busy, done, bus.mem_load, bus.mem_in);
    end
    model_job(1'b1, 0, 'h200, 1, 16'h5A5A);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(4, 0, 0, nb, nd, nl);
    check_job("reset_idle", nb, nd, nl, 0, 0, 0);
    check_ram("reset_mid_wr");
  endtask

  task automatic test_fill();
    int nb, nd, nl;
    start_job(1'b1, 0, 'h100, 4, 16'hBEEF);
    run(50, 0, 0, nb, nd, nl);
    model_job(1'b1, 0, 'h100, 4, 16'hBEEF);
    check_job("fill", nb, nd, nl, 5, 1, 4);
    check_ram("fill");
  endtask

  task automatic test_copy();
    int nb, nd, nl;
    for (int i = 0; i < 3; i++) begin
      ram['h10 + i]   = 16'(i + 1);
      model['h10 + i] = 16'(i + 1);
    end
    start_job(1'b0, 'h10, 'h20, 3, 16'h0);
    run(50, 0, 0, nb, nd, nl);
    model_job(1'b0, 'h10, 'h20, 3, 16'h0);
    check_job("copy", nb, nd, nl, 7, 1, 3);
    check_ram("copy");
  endtask

  task automatic test_len_zero();
    int nb, nd, nl;
    start_job(1'b0, 'h40, 'h50, 0, 16'h0);
    run(50, 0, 0, nb, nd, nl);
    check_job("len_zero", nb, nd, nl, 1, 1, 0);
    check_ram("len_zero");
  endtask

  task automatic test_wrap();
    int nb, nd, nl;
    int exp_a [$];
    exp_a = '{'h3FFE, 'h3FFF, 'h0000, 'h0001};
    start_job(1'b1, 0, 'h3FFE, 4, 16'hC0DE);
    run(50, 0, 0, nb, nd, nl);
    model_job(1'b1, 0, 'h3FFE, 4, 16'hC0DE);
    check_job("wrap", nb, nd, nl, 5, 1, 4);
    tests++;
    if (waddr !== exp_a) begin
      fails++;
      $display("FAIL wrap_addr: got %p want %p", waddr, exp_a);
    end
    check_ram("wrap");
  endtask

  task automatic test_overlap_restart();
    int nb, nd, nl;
    ram[0]   = 16'd7;
    model[0] = 16'd7;
    start_job(1'b0, 0, 1, 3, 16'h0);
    mode     = 1'b1;
    dst      = AW'('h300);
    len      = AW'(5);
    fill_val = 16'hDEAD;
    run(50, 2, 0, nb, nd, nl);
    model_job(1'b0, 0, 1, 3, 16'h0);
    check_job("overlap", nb, nd, nl, 7, 1, 3);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL restart_ignored: busy %b want 0", busy);
    end
    check_ram("overlap");
  endtask

  task automatic test_abort();
    int nb, nd, nl;
    start_job(1'b1, 0, 'h400, 8, 16'h1234);
    run(50, 0, 3, nb, nd, nl);
    model_job(1'b1, 0, 'h400, 3, 16'h1234);
    check_job("abort", nb, nd, nl, 3, 0, 3);
    check_ram("abort");
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_with_start: busy %b want 0", busy);
    end
    start_job(1'b1, 0, 'h500, 2, 16'h4321);
    run(50, 0, 0, nb, nd, nl);
    model_job(1'b1, 0, 'h500, 2, 16'h4321);
    check_job("after_abort", nb, nd, nl, 3, 1, 2);
    check_ram("after_abort");
  endtask

  task automatic test_random();
    int nb, nd, nl, s, d, n, eb;
    logic m;
    logic [15:0] fv;
    for (int k = 0; k < 8; k++) begin
      m  = 1'($urandom);
      s  = int'($urandom_range(DEPTH - 1));
      d  = int'($urandom_range(DEPTH - 1));
      n  = int'($urandom_range(20));
      fv = 16'($urandom);
      if (k == 0) begin
        m = 1'b0;
        s = DEPTH - 5;
        d = s + 2;
        n = 9;
      end
      start_job(m, s, d, n, fv);
      run(200, 0, 0, nb, nd, nl);
      model_job(m, s, d, n, fv);
      eb = (n == 0) ? 1 : (m ? n + 1 : 2 * n + 1);
      check_job("random", nb, nd, nl, eb, 1, n);
      check_ram("random");
    end
  endtask

  initial begin
    init_mem();
    test_reset();
    test_fill();
    test_copy();
    test_len_zero();
    test_wrap();
    test_overlap_restart();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
